// File: rtl/adpcm_update_sched_if.sv
// Bus bundle for adpcm_update_sched: upward ap_ctrl_hs handshake, per-sub-block
// start/done, per-client memory requests, and the shared memory port.
interface adpcm_update_sched_if #(
  parameter int NUM_SUB = 3,
  parameter int AW      = 3,
  parameter int DW      = 32
);
  // Handshake: ap_start is a level request sampled only while idle; ap_done and
  // ap_ready pulse together for one cycle at sequence end. sub_start[i] is held
  // for every cycle block i runs and drops the cycle after sub_done[i] is seen.
  logic                    ap_start;
  logic                    ap_done;
  logic                    ap_idle;
  logic                    ap_ready;
  logic [NUM_SUB-1:0]      skip_mask;
  logic [NUM_SUB-1:0]      sub_start;
  logic [NUM_SUB-1:0]      sub_done;
  logic [NUM_SUB*AW-1:0]   c_address;
  logic [NUM_SUB-1:0]      c_ce;
  logic [NUM_SUB-1:0]      c_we;
  logic [NUM_SUB*DW-1:0]   c_d;
  logic [AW-1:0]           mem_address;
  logic                    mem_ce;
  logic                    mem_we;
  logic [DW-1:0]           mem_d;
  logic [NUM_SUB-1:0]      grant;
  logic                    timeout_err;
  logic [15:0]             run_cycles;
  logic [1:0]              dbg_state;

  modport master (
    output ap_start, skip_mask, sub_done, c_address, c_ce, c_we, c_d,
    input  ap_done, ap_idle, ap_ready, sub_start, mem_address, mem_ce, mem_we,
           mem_d, grant, timeout_err, run_cycles, dbg_state
  );

  modport slave (
    input  ap_start, skip_mask, sub_done, c_address, c_ce, c_we, c_d,
    output ap_done, ap_idle, ap_ready, sub_start, mem_address, mem_ce, mem_we,
           mem_d, grant, timeout_err, run_cycles, dbg_state
  );
endinterface

// File: rtl/adpcm_update_sched.sv
// Sequences the ADPCM predictor-update sub-blocks and muxes their shared memory port.
// Optional cycle statistics on run_cycles are enabled by ADPCM_SCHED_STATS_EN.
module adpcm_update_sched #(
  parameter int NUM_SUB = 3,
  parameter int AW      = 3,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  adpcm_update_sched_if.slave  bus
);
  localparam int IW = $clog2(NUM_SUB + 1);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_RUN, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [IW-1:0]      r_idx, w_idx_nxt;
  logic [15:0]        r_cnt, w_cnt_nxt;
  logic [NUM_SUB-1:0] r_mask, w_mask_nxt;
  logic               r_err, w_err_nxt;
  logic               w_cur_mask;
  logic               w_cur_done;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_mask  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mask  <= w_mask_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_cur_mask = 1'b0;
    w_cur_done = 1'b0;
    for (int i = 0; i < NUM_SUB; i++) begin
      if (r_idx == IW'(i)) begin
        w_cur_mask = r_mask[i];
        w_cur_done = bus.sub_done[i];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_mask_nxt  = r_mask;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (bus.ap_start) begin
          w_mask_nxt  = bus.skip_mask;
          w_idx_nxt   = '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_SELECT;
        end
      end
      S_SELECT: begin
        if (r_idx == IW'(NUM_SUB)) begin
          w_state_nxt = S_DONE;
        end else if (w_cur_mask) begin
          w_idx_nxt = r_idx + IW'(1);
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // A done on the last allowed cycle wins over the abort below.
        if (w_cur_done) begin
          w_idx_nxt   = r_idx + IW'(1);
          w_state_nxt = S_SELECT;
        end else begin
          if (r_cnt != 16'hFFFF) w_cnt_nxt = r_cnt + 16'd1;
          if (r_cnt >= 16'(TIMEOUT - 1)) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.grant       = '0;
    bus.mem_address = '0;
    bus.mem_ce      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_d       = '0;
    for (int i = 0; i < NUM_SUB; i++) begin
      if ((r_state == S_RUN) && (r_idx == IW'(i))) begin
        bus.grant[i]    = 1'b1;
        bus.mem_address = bus.c_address[i*AW +: AW];
        bus.mem_ce      = bus.c_ce[i];
        bus.mem_we      = bus.c_we[i];
        bus.mem_d       = bus.c_d[i*DW +: DW];
      end
    end
  end

  assign bus.sub_start   = bus.grant;
  assign bus.ap_done     = (r_state == S_DONE);
  assign bus.ap_ready    = (r_state == S_DONE);
  assign bus.ap_idle     = (r_state == S_IDLE) && !bus.ap_start;
  assign bus.timeout_err = r_err;
  assign bus.dbg_state   = r_state;

`ifdef ADPCM_SCHED_STATS_EN
  logic [15:0] r_stat_cnt;
  logic [15:0] r_run_cycles;
  logic [15:0] w_stat_inc;

  assign w_stat_inc = (r_stat_cnt == 16'hFFFF) ? r_stat_cnt : r_stat_cnt + 16'd1;

  // The DONE cycle itself is counted, hence latching the incremented value.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_stat_cnt   <= '0;
      r_run_cycles <= '0;
    end else if (r_state == S_IDLE) begin
      if (bus.ap_start) r_stat_cnt <= '0;
    end else begin
      r_stat_cnt <= w_stat_inc;
      if (r_state == S_DONE) r_run_cycles <= w_stat_inc;
    end
  end

  assign bus.run_cycles = r_run_cycles;
`else
  assign bus.run_cycles = '0;
`endif
endmodule

// File: tb/tb_adpcm_update_sched.sv
// Randomized scoreboard bench for adpcm_update_sched with behavioural sub-block models.
module tb_adpcm_update_sched;
  localparam int NUM_SUB = 3;
  localparam int AW      = 3;
  localparam int DW      = 32;
  localparam int TIMEOUT = 255;
  localparam int CAW     = NUM_SUB * AW;

  typedef struct packed {
    logic [31:0] lat;
    logic        err;
    logic [31:0] accept;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  adpcm_update_sched_if #(.NUM_SUB(NUM_SUB), .AW(AW), .DW(DW)) bus ();

  adpcm_update_sched #(.NUM_SUB(NUM_SUB), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   exp_pulse_q[$];
  int   obs_pulse_q[$];
  int   dly[NUM_SUB];
  int   sub_cnt[NUM_SUB];
  int   run_len[NUM_SUB];
  bit   model_err = 1'b0;
  bit   rc_chk = 1'b0;
  int   rc_exp = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: sequence latency and start pulses from the documented sequencing rules.
  task automatic build_expect(input logic [NUM_SUB-1:0] m, output int lat, output bit err);
    lat = 0;
    err = 1'b0;
    for (int i = 0; i < NUM_SUB && !err; i++) begin
      if (m[i]) begin
        lat += 1;
      end else if (dly[i] == 0 || dly[i] > TIMEOUT) begin
        lat += 1 + TIMEOUT;
        exp_pulse_q.push_back(i * 1000 + TIMEOUT);
        err = 1'b1;
      end else begin
        lat += 1 + dly[i];
        exp_pulse_q.push_back(i * 1000 + dly[i]);
      end
    end
    lat += err ? 1 : 2;
  endtask

  // ---------------- drivers: clients and sub-block models ----------------
  initial forever begin
    @(negedge clk);
    bus.c_address = CAW'($urandom);
    bus.c_ce      = NUM_SUB'($urandom);
    bus.c_we      = NUM_SUB'($urandom);
    bus.c_d       = {$urandom, $urandom, $urandom};
    for (int i = 0; i < NUM_SUB; i++) begin
      if (bus.sub_start[i] === 1'b1) begin
        sub_cnt[i]++;
        bus.sub_done[i] = (dly[i] != 0) && (sub_cnt[i] == dly[i]);
      end else begin
        sub_cnt[i] = 0;
        bus.sub_done[i] = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!bus.ap_idle && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_before_start", bus.ap_idle, 1);
  endtask

  task automatic accept(input logic [NUM_SUB-1:0] mask);
    bus.skip_mask = mask;
    bus.ap_start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ap_start  = 1'b0;
    bus.skip_mask = NUM_SUB'($urandom);
    check("err_cleared_at_accept", bus.timeout_err, 0);
  endtask

  task automatic run_seq(input logic [NUM_SUB-1:0] mask, input int d0, input int d1, input int d2);
    int   lat;
    bit   err;
    int   n;
    exp_t e;
    dly[0] = d0;
    dly[1] = d1;
    dly[2] = d2;
    wait_idle();
    check("sticky_err", bus.timeout_err, model_err);
    accept(mask);
    build_expect(mask, lat, err);
    e.lat = lat;
    e.err = err;
    e.accept = cyc;
    exp_q.push_back(e);
    model_err = err;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * TIMEOUT + 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL seq_done_timeout: ap_done not seen within %0d cycles (mask=%b)", n, mask);
      exp_q.delete();
      exp_pulse_q.delete();
      obs_pulse_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic reset_mid_run();
    int n = 0;
    dly[0] = 3;
    dly[1] = 0;
    dly[2] = 5;
    wait_idle();
    accept('0);
    while (bus.sub_start[1] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_run_idx1", bus.sub_start[1], 1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_sub_start", bus.sub_start, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_mem_ce", bus.mem_ce, 0);
    check("rst_ap_done", bus.ap_done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2;
    check("post_rst_idle", bus.ap_idle, 1);
    check("post_rst_run_cycles", bus.run_cycles, 0);
    exp_pulse_q.delete();
    obs_pulse_q.delete();
    model_err = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    logic [AW-1:0] ea;
    logic          ece, ewe;
    logic [DW-1:0] ed;
    exp_t          e;
    @(negedge clk);
    #1;
    for (int i = 0; i < NUM_SUB; i++) begin
      if (bus.sub_start[i] === 1'b1) run_len[i]++;
      else if (run_len[i] > 0) begin
        obs_pulse_q.push_back(i * 1000 + run_len[i]);
        run_len[i] = 0;
      end
    end
    ea = '0; ece = 1'b0; ewe = 1'b0; ed = '0;
    for (int i = 0; i < NUM_SUB; i++) begin
      if (bus.sub_start[i] === 1'b1) begin
        ea  = bus.c_address[i*AW +: AW];
        ece = bus.c_ce[i];
        ewe = bus.c_we[i];
        ed  = bus.c_d[i*DW +: DW];
      end
    end
    check("sub_start_onehot0", $onehot0(bus.sub_start), 1);
    check("grant_eq_sub_start", bus.grant, bus.sub_start);
    check("mem_address", bus.mem_address, ea);
    check("mem_ce", bus.mem_ce, ece);
    check("mem_we", bus.mem_we, ewe);
    check("mem_d", bus.mem_d, ed);
    if (rc_chk) begin
      check("run_cycles", bus.run_cycles, rc_exp);
      rc_chk = 1'b0;
    end
    if (bus.ap_done || bus.ap_ready) check("ap_ready_eq_ap_done", bus.ap_ready, bus.ap_done);
    if (bus.ap_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ap_done: ap_done=1 with no sequence outstanding (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("latency", cyc - int'(e.accept) + 1, e.lat);
        check("timeout_err_at_done", bus.timeout_err, e.err);
        check("start_pulse_count", obs_pulse_q.size(), exp_pulse_q.size());
        while (obs_pulse_q.size() != 0 && exp_pulse_q.size() != 0)
          check("start_pulse_idx_len", obs_pulse_q.pop_front(), exp_pulse_q.pop_front());
        obs_pulse_q.delete();
        exp_pulse_q.delete();
`ifdef ADPCM_SCHED_STATS_EN
        rc_exp = (e.lat > 65535) ? 65535 : int'(e.lat);
`else
        rc_exp = 0;
`endif
        rc_chk = 1'b1;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [NUM_SUB-1:0] m;
    int                 d[NUM_SUB];
    bus.ap_start  = 1'b0;
    bus.skip_mask = '0;
    bus.sub_done  = '0;
    for (int i = 0; i < NUM_SUB; i++) begin
      dly[i] = 1;
      sub_cnt[i] = 0;
      run_len[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("reset_ap_done", bus.ap_done, 0);
    check("reset_ap_ready", bus.ap_ready, 0);
    check("reset_ap_idle", bus.ap_idle, 1);
    check("reset_sub_start", bus.sub_start, 0);
    check("reset_timeout_err", bus.timeout_err, 0);
    check("reset_run_cycles", bus.run_cycles, 0);
    rst = 1'b0;

    run_seq(3'b000, 10, 10, 10);
    run_seq(3'b010, 4, 4, 4);
    run_seq(3'b111, 5, 5, 5);
    run_seq(3'b000, 3, 0, 6);
    run_seq(3'b000, 2, 2, 2);
    run_seq(3'b000, TIMEOUT, 1, 1);
    run_seq(3'b100, TIMEOUT + 1, 1, 1);
    run_seq(3'b001, 1, 1, 1);
    reset_mid_run();
    run_seq(3'b000, 1, 2, 3);
    for (int k = 0; k < 14; k++) begin
      m = NUM_SUB'($urandom_range(0, 7));
      for (int i = 0; i < NUM_SUB; i++)
        d[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
      run_seq(m, d[0], d[1], d[2]);
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_watchdog: simulation exceeded time limit");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end
endmodule
